led_matrix_scan: RTL and testbench

Scan driver for the 64x32 RGB LED panel (two half-panels, 1/16 scan). It generates the `col`/`row` coordinates consumed by the upstream pixel generator and samples that generator's six colour bits. It then drives the panel's serial interface: shift clock, latch, output-enable, row address and registered colour data. It sits between the pixel-generation stage and the panel connector, and is the only block that touches the panel pins.

---
 rtl/led_matrix_scan.sv | 122 ++++++++++++
 tb/tb_led_matrix_scan.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
// rtl/led_matrix_scan.sv - 1/16-scan RGB LED panel driver: column fetch, serial shift, latch and display timing
module led_matrix_scan #(
    parameter int COLS      = 64,
    parameter int ROWS      = 16,
    parameter int ON_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic [$clog2(COLS)-1:0]   col,
    output logic [$clog2(ROWS)-1:0]   row,
    input  logic                      R0,
    input  logic                      G0,
    input  logic                      B0,
    input  logic                      R1,
    input  logic                      G1,
    input  logic                      B1,
    output logic                      mat_clk,
    output logic                      mat_lat,
    output logic                      mat_oe_n,
    output logic [$clog2(ROWS)-1:0]   addr,
    output logic                      r0,
    output logic                      g0,
    output logic                      b0,
    output logic                      r1,
    output logic                      g1,
    output logic                      b1,
    output logic                      frame_tick
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int OW = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [OW-1:0] ON_LAST  = OW'(ON_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_BLANK   = 3'd2;
    localparam logic [2:0] ST_LATCH   = 3'd3;
    localparam logic [2:0] ST_DISPLAY = 3'd4;

    logic [2:0]    state;
    logic          ph;
    logic [OW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ph         <= 1'b0;
            cnt        <= '0;
            col        <= '0;
            row        <= '0;
            addr       <= '0;
            mat_clk    <= 1'b0;
            mat_lat    <= 1'b0;
            mat_oe_n   <= 1'b1;
            frame_tick <= 1'b0;
            {r0, g0, b0, r1, g1, b1} <= 6'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mat_oe_n <= 1'b1;
                    mat_clk  <= 1'b0;
                    mat_lat  <= 1'b0;
                    col      <= '0;
                    ph       <= 1'b0;
                    if (en) state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Data moves on the falling shift clock so it is settled a full cycle before the rise
                    if (!ph) begin
                        {r0, g0, b0, r1, g1, b1} <= {R0, G0, B0, R1, G1, B1};
                        mat_clk <= 1'b0;
                        ph      <= 1'b1;
                    end else begin
                        mat_clk <= 1'b1;
                        ph      <= 1'b0;
                        if (col == COL_LAST) state <= ST_BLANK;
                        else                 col   <= col + 1'b1;
                    end
                end
                ST_BLANK: begin
                    mat_clk  <= 1'b0;
                    mat_oe_n <= 1'b1;
                    state    <= ST_LATCH;
                end
                ST_LATCH: begin
                    mat_lat <= 1'b1;
                    addr    <= row;
                    cnt     <= '0;
                    state   <= ST_DISPLAY;
                end
                ST_DISPLAY: begin
                    if (cnt == '0) begin
                        mat_lat  <= 1'b0;
                        mat_oe_n <= 1'b0;
                    end
                    if (cnt == ON_LAST) begin
                        cnt        <= '0;
                        col        <= '0;
                        row        <= (row == ROW_LAST) ? '0 : row + 1'b1;
                        frame_tick <= (row == ROW_LAST);
                        if (en) begin
                            state <= ST_SHIFT;
                        end else begin
                            state    <= ST_IDLE;
                            mat_oe_n <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb/tb_led_matrix_scan.sv - scoreboard bench for led_matrix_scan
module tb_led_matrix_scan;

    localparam int ROW_PERIOD   = 194;
    localparam int FRAME_PERIOD = 3104;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [5:0] col;
    logic [3:0] row;
    logic       up_r0, up_g0, up_b0, up_r1, up_g1, up_b1;
    logic       mat_clk, mat_lat, mat_oe_n;
    logic [3:0] addr;
    logic       r0, g0, b0, r1, g1, b1;
    logic       frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t       = 0;
    int start_cyc = 0;
    int tick_cnt  = 0;
    int last_tick = 0;

    logic [5:0] exp_pix[$];
    logic [3:0] exp_lat[$];

    logic       prev_mclk = 1'b0;
    logic       prev_lat  = 1'b0;
    logic       prev_tick = 1'b0;
    logic [3:0] prev_addr = 4'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign up_r0 = col[0];
    assign up_g0 = col[1];
    assign up_b0 = col[5];
    assign up_r1 = row[1];
    assign up_g1 = row[3];
    assign up_b1 = row[0];

    led_matrix_scan #(.COLS(64), .ROWS(16), .ON_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .en(en), .col(col), .row(row),
        .R0(up_r0), .G0(up_g0), .B0(up_b0), .R1(up_r1), .G1(up_g1), .B1(up_b1),
        .mat_clk(mat_clk), .mat_lat(mat_lat), .mat_oe_n(mat_oe_n), .addr(addr),
        .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .frame_tick(frame_tick)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic missing(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT output with no expected entry (cycle %0d)", name, cyc);
    endtask

    task automatic push_row(input int r);
        logic [5:0] k;
        logic [3:0] rr;
        rr = 4'(r);
        for (int c = 0; c < 64; c++) begin
            k = 6'(c);
            exp_pix.push_back({k[0], k[1], k[5], rr[1], rr[3], rr[0]});
        end
        exp_lat.push_back(rr);
    endtask

    task automatic wait_to(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    // Monitor: pops expectations on each shift-clock rise and latch strobe
    always @(negedge clk) begin
        if (mat_clk && !prev_mclk) begin
            if (exp_pix.size() == 0) missing("pix_extra");
            else chk("pix_data", int'({r0, g0, b0, r1, g1, b1}), int'(exp_pix.pop_front()));
        end
        if (mat_lat) begin
            chk("lat_oe_n", int'(mat_oe_n), 1);
            chk("lat_width", int'(prev_lat), 0);
            if (exp_lat.size() == 0) missing("lat_extra");
            else chk("lat_addr", int'(addr), int'(exp_lat.pop_front()));
        end
        if (addr != prev_addr) chk("addr_change_oe_n", int'(mat_oe_n), 1);
        if (frame_tick) begin
            chk("tick_width", int'(prev_tick), 0);
            tick_cnt++;
            if (tick_cnt == 1) chk("tick_first", cyc - start_cyc, FRAME_PERIOD);
            else chk("tick_period", cyc - last_tick, FRAME_PERIOD);
            last_tick = cyc;
        end
        prev_mclk = mat_clk;
        prev_lat  = mat_lat;
        prev_tick = frame_tick;
        prev_addr = addr;
    end

    int r4;
    int rz;

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_col", int'(col), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_mat_clk", int'(mat_clk), 0);
        chk("rst_mat_lat", int'(mat_lat), 0);
        chk("rst_oe_n", int'(mat_oe_n), 1);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_colour", int'({r0, g0, b0, r1, g1, b1}), 0);

        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 16; r++) push_row(r);
        for (int r = 0; r < 5; r++) push_row(r);

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_cyc = cyc;
        t = 0;
        chk("r0_start_col", int'(col), 0);
        chk("r0_start_oe_n", int'(mat_oe_n), 1);
        wait_to(2);
        chk("r0_first_inc", int'(col), 1);
        wait_to(129);
        chk("r0_latch_state_lat", int'(mat_lat), 0);
        chk("r0_latch_state_oe_n", int'(mat_oe_n), 1);
        chk("r0_latch_state_mclk", int'(mat_clk), 0);
        wait_to(130);
        chk("r0_lat_pulse", int'(mat_lat), 1);
        chk("r0_lat_addr", int'(addr), 0);
        wait_to(131);
        chk("r0_disp_lat", int'(mat_lat), 0);
        chk("r0_disp_oe_n", int'(mat_oe_n), 0);
        wait_to(193);
        chk("r0_disp_end_oe_n", int'(mat_oe_n), 0);
        chk("r0_disp_end_row", int'(row), 0);
        wait_to(194);
        chk("r1_row", int'(row), 1);
        chk("r1_col", int'(col), 0);
        wait_to(204);
        chk("r1_shift_oe_n", int'(mat_oe_n), 0);

        wait_to(15 * ROW_PERIOD + 193);
        chk("wrap_pre_row", int'(row), 15);
        wait_to(FRAME_PERIOD);
        chk("wrap_row", int'(row), 0);
        chk("wrap_tick", int'(frame_tick), 1);
        wait_to(FRAME_PERIOD + 1);
        chk("wrap_tick_clear", int'(frame_tick), 0);

        wait_to(2 * FRAME_PERIOD + 3 * ROW_PERIOD + 40);
        chk("drop_col", int'(col), 20);
        chk("drop_row", int'(row), 3);
        en = 1'b0;
        wait_to(2 * FRAME_PERIOD + 3 * ROW_PERIOD + 130);
        chk("drop_lat", int'(mat_lat), 1);
        chk("drop_addr", int'(addr), 3);
        wait_to(2 * FRAME_PERIOD + 3 * ROW_PERIOD + 193);
        chk("drop_last_disp_oe_n", int'(mat_oe_n), 0);
        wait_to(2 * FRAME_PERIOD + 4 * ROW_PERIOD);
        chk("idle_oe_n", int'(mat_oe_n), 1);
        chk("idle_row", int'(row), 4);
        chk("idle_col", int'(col), 0);
        wait_to(2 * FRAME_PERIOD + 4 * ROW_PERIOD + 10);
        chk("idle_hold_col", int'(col), 0);
        chk("idle_hold_mclk", int'(mat_clk), 0);
        chk("idle_hold_oe_n", int'(mat_oe_n), 1);
        en = 1'b1;

        r4 = 2 * FRAME_PERIOD + 4 * ROW_PERIOD + 11;
        wait_to(r4);
        chk("resume_row", int'(row), 4);
        chk("resume_col", int'(col), 0);
        wait_to(r4 + 2);
        chk("resume_inc", int'(col), 1);
        wait_to(r4 + 130);
        chk("resume_lat_addr", int'(addr), 4);
        wait_to(r4 + 140);
        chk("pre_rst_oe_n", int'(mat_oe_n), 0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_oe_n", int'(mat_oe_n), 1);
        chk("async_rst_row", int'(row), 0);
        chk("async_rst_addr", int'(addr), 0);
        chk("async_rst_lat", int'(mat_lat), 0);
        chk("async_rst_col", int'(col), 0);

        wait_to(r4 + 142);
        push_row(0);
        rst = 1'b1;
        rz = r4 + 143;
        wait_to(rz);
        chk("restart_row", int'(row), 0);
        chk("restart_oe_n", int'(mat_oe_n), 1);
        wait_to(rz + 130);
        chk("restart_lat", int'(mat_lat), 1);
        chk("restart_addr", int'(addr), 0);
        wait_to(rz + 131);
        chk("restart_disp_oe_n", int'(mat_oe_n), 0);
        wait_to(rz + 135);

        chk("pix_left_over", exp_pix.size(), 0);
        chk("lat_left_over", exp_lat.size(), 0);
        chk("tick_count", tick_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
